result_tx_interface: RTL and testbench
======================================

# result_tx_interface

Transmit-side glue between the ALU result and `tx_module` in the BIP UART datapath: the counterpart of the receive-side `interface` block. When the receive side flags a complete operand/opcode set (`rx_empty` low), it captures the ALU result, acknowledges the receive side with a one-cycle `rd` pulse, and launches one `tx_module` frame. It then waits for `tx_done_tick`. A watchdog returns the block to idle if the transmitter never completes.

## Interface
- `DBIT`, 8: data width of result and UART frame.
- `CNT_W`, 17: watchdog counter width.
- `TIMEOUT`, 100000: cycles to wait for `tx_done_tick` before abort; must be < 2^CNT_W and > 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_empty`  in  1  low = new result available from receive side.
- `result`  in  DBIT  ALU result; valid whenever `rx_empty` is low.
- `tx_done_tick`  in  1  one-cycle pulse from `tx_module` at end of stop bit.
- `d_in`  out  DBIT  byte to `tx_module`; registered.
- `tx_start`  out  1  one-cycle start pulse to `tx_module`; registered.
- `rd`  out  1  one-cycle acknowledge to receive side; registered.
- `busy`  out  1  high in any state other than IDLE.
- `tx_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
States: IDLE, START, WAIT.
- IDLE:
  - `tx_start`=0, `busy`=0, counter cleared.
  - If `rx_empty`==0: latch `result` into `d_in`, set `rd`=1 for the next cycle, go START.
  - `tx_done_tick` in IDLE is ignored.
- START:
  - `rd`=0, `tx_start`=1 for exactly this one cycle, go WAIT.
  - `d_in` holds the latched value.
- WAIT:
  - `tx_start`=0; counter increments each cycle.
  - On `tx_done_tick`=1: go IDLE, no error.
  - Else if counter == TIMEOUT-1: go IDLE, `tx_err`=1 for one cycle.
  - If `tx_done_tick` and the timeout coincide, `tx_done_tick` wins and `tx_err` stays 0.
- `d_in` is held stable from the latch until the next latch; it changes only on an IDLE→START transition.
- `result` changes while in START or WAIT are ignored. No re-latch occurs until back in IDLE.
- If `rx_empty` is still low on return to IDLE, that is a new result: it is latched and sent. The receive side must raise `rx_empty` within one cycle of `rd`.
- Exactly one `rd` pulse and at most one `tx_start` pulse per accepted result.

## Timing
- Reset (`reset`=0 at an edge):
  - Next state is IDLE.
  - `d_in`=0, `tx_start`=0, `rd`=0, `busy`=0, `tx_err`=0, counter=0.
  - This applies from any state, including mid-WAIT. The abandoned frame is not re-sent.
- Handshake sequence: `rx_empty` sampled low at edge k. Then:
  - edge k: `d_in`=result, `rd`=1, `busy`=1.
  - edge k+1: `rd`=0, `tx_start`=1.
  - edge k+2: `tx_start`=0.
- Latency from `rx_empty` low to `tx_start` high: 2 cycles.
- Return to IDLE: `tx_done_tick` sampled high at edge m in WAIT gives `busy`=0 at edge m. A new result can be latched at edge m+1 at the earliest.
- Abort: `tx_err` is high for the single cycle following the abort edge; `busy` falls on the same edge.
- The counter never wraps: it saturates by leaving WAIT.

## Test plan
- Basic send: reset low 2 cycles, then `result`=8'hA5, `rx_empty` 1→0.
  - Required: `rd` high 1 cycle, `tx_start` high 1 cycle one cycle later, `d_in`=A5 held.
  - After `tx_done_tick` 20 cycles later: `busy`=0, no `tx_err`.
- Result changes mid-frame: after latching 8'h3C, drive `result`=8'hFF during WAIT.
  - Required: `d_in` stays 3C, no extra `tx_start` or `rd`.
- Back-to-back: keep `rx_empty` low with `result`=8'h01 then 8'h02 across two `tx_done_tick`s.
  - Required: two frames, `d_in` 01 then 02, two `rd` pulses, two `tx_start` pulses.
- Watchdog, TIMEOUT=16: send 8'h55 and never pulse `tx_done_tick`.
  - Required: `tx_err` pulse on the cycle after cycle 16 of WAIT, `busy`=0, then a new result is accepted normally.
- Reset mid-WAIT: assert `reset`=0 for 1 cycle during WAIT.
  - Required: all outputs 0 at the next edge, IDLE, no spurious `tx_start` afterwards.
- Spurious done: pulse `tx_done_tick` in IDLE with `rx_empty`=1.
  - Required: no state change, all outputs stay 0.

Source files
------------

// File: rtl/result_tx_interface.sv
// rtl/result_tx_interface.sv - hands each ALU result to tx_module and waits for the frame to finish
module result_tx_interface #(
    parameter int DBIT    = 8,
    parameter int CNT_W   = 17,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] result,
    input  logic            tx_done_tick,
    output logic [DBIT-1:0] d_in,
    output logic            tx_start,
    output logic            rd,
    output logic            busy,
    output logic            tx_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            d_in     <= '0;
            tx_start <= 1'b0;
            rd       <= 1'b0;
            busy     <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            // rd, tx_start and tx_err are single-cycle pulses unless re-asserted below
            rd       <= 1'b0;
            tx_start <= 1'b0;
            tx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (!rx_empty) begin
                        d_in  <= result;
                        rd    <= 1'b1;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    cnt      <= '0;
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    // a done tick on the final watchdog cycle still counts as a clean finish
                    if (tx_done_tick) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        busy   <= 1'b0;
                        tx_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_tx_interface.sv
// tb/tb_result_tx_interface.sv - directed scoreboard bench for result_tx_interface
module tb_result_tx_interface;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic       w_rx_empty;
    logic [7:0] result;
    logic       tx_done_tick;

    logic [7:0] d_in,   w_d_in;
    logic       tx_start, w_tx_start;
    logic       rd,       w_rd;
    logic       busy,     w_busy;
    logic       tx_err,   w_tx_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int rd_cnt = 0;
    int start_cnt = 0;
    int n;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    result_tx_interface #(.DBIT(8), .CNT_W(17), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .result(result),
        .tx_done_tick(tx_done_tick), .d_in(d_in), .tx_start(tx_start),
        .rd(rd), .busy(busy), .tx_err(tx_err)
    );

    result_tx_interface #(.DBIT(8), .CNT_W(17), .TIMEOUT(16)) dut_wd (
        .clk(clk), .reset(reset), .rx_empty(w_rx_empty), .result(result),
        .tx_done_tick(tx_done_tick), .d_in(w_d_in), .tx_start(w_tx_start),
        .rd(w_rd), .busy(w_busy), .tx_err(w_tx_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Scoreboard: every tx_start must carry the oldest accepted result
    always @(negedge clk) begin
        if (rd) rd_cnt++;
        if (tx_start) begin
            start_cnt++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sb_d_in", 32'(d_in), 32'(sb.pop_front()));
        end
    end

    initial begin
        reset = 1'b0; rx_empty = 1'b1; w_rx_empty = 1'b1; result = 8'h00; tx_done_tick = 1'b0;
        tick(2);
        check("reset_outputs", 32'({d_in, tx_start, rd, busy, tx_err}), 32'd0);
        check("reset_outputs_wd", 32'({w_d_in, w_tx_start, w_rd, w_busy, w_tx_err}), 32'd0);
        reset = 1'b1;
        tick(1);

        // basic send
        result = 8'hA5; sb.push_back(8'hA5); rx_empty = 1'b0;
        tick(1);
        check("basic_rd", 32'(rd), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_d_in", 32'(d_in), 32'hA5);
        check("basic_no_early_start", 32'(tx_start), 32'd0);
        rx_empty = 1'b1;
        tick(1);
        check("basic_rd_fall", 32'(rd), 32'd0);
        check("basic_tx_start", 32'(tx_start), 32'd1);
        tick(1);
        check("basic_tx_start_fall", 32'(tx_start), 32'd0);
        tick(19);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("basic_busy_clear", 32'(busy), 32'd0);
        check("basic_no_err", 32'(tx_err), 32'd0);
        check("basic_d_in_held", 32'(d_in), 32'hA5);
        check("basic_pulses", 32'({rd_cnt[7:0], start_cnt[7:0]}), 32'h0101);

        // result changes mid-frame
        result = 8'h3C; sb.push_back(8'h3C); rx_empty = 1'b0;
        tick(1);
        rx_empty = 1'b1;
        tick(2);
        result = 8'hFF;
        tick(5);
        check("midframe_d_in", 32'(d_in), 32'h3C);
        check("midframe_pulses", 32'({rd_cnt[7:0], start_cnt[7:0]}), 32'h0202);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("midframe_busy_clear", 32'(busy), 32'd0);
        check("midframe_d_in_after", 32'(d_in), 32'h3C);

        // back-to-back with rx_empty held low
        result = 8'h01; sb.push_back(8'h01); rx_empty = 1'b0;
        tick(1);
        check("b2b_rd1", 32'(rd), 32'd1);
        check("b2b_d_in1", 32'(d_in), 32'h01);
        tick(1);
        check("b2b_start1", 32'(tx_start), 32'd1);
        tick(3);
        result = 8'h02; sb.push_back(8'h02);
        tick(3);
        check("b2b_hold1", 32'(d_in), 32'h01);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("b2b_idle", 32'(busy), 32'd0);
        tick(1);
        check("b2b_rd2", 32'(rd), 32'd1);
        check("b2b_d_in2", 32'(d_in), 32'h02);
        rx_empty = 1'b1;
        tick(1);
        check("b2b_start2", 32'(tx_start), 32'd1);
        tick(4);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("b2b_busy_clear", 32'(busy), 32'd0);
        check("b2b_pulses", 32'({rd_cnt[7:0], start_cnt[7:0]}), 32'h0404);

        // reset mid-WAIT
        result = 8'h77; sb.push_back(8'h77); rx_empty = 1'b0;
        tick(1);
        rx_empty = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("rst_wait_outputs", 32'({d_in, tx_start, rd, busy, tx_err}), 32'd0);
        reset = 1'b1;
        tick(10);
        check("rst_wait_quiet", 32'({d_in, tx_start, rd, busy, tx_err}), 32'd0);
        check("rst_wait_pulses", 32'({rd_cnt[7:0], start_cnt[7:0]}), 32'h0505);

        // spurious done in IDLE
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("spurious_outputs", 32'({d_in, tx_start, rd, busy, tx_err}), 32'd0);
        tick(2);
        check("spurious_quiet", 32'({d_in, tx_start, rd, busy, tx_err}), 32'd0);
        check("spurious_pulses", 32'({rd_cnt[7:0], start_cnt[7:0]}), 32'h0505);

        // watchdog with TIMEOUT=16
        result = 8'h55; w_rx_empty = 1'b0;
        tick(1);
        check("wd_rd", 32'(w_rd), 32'd1);
        check("wd_d_in", 32'(w_d_in), 32'h55);
        w_rx_empty = 1'b1;
        tick(1);
        check("wd_start", 32'(w_tx_start), 32'd1);
        n = 0;
        while (!w_tx_err && n < 40) begin
            tick(1);
            n++;
        end
        check("wd_err_latency", 32'(n), 32'd16);
        check("wd_busy_clear", 32'(w_busy), 32'd0);
        tick(1);
        check("wd_err_one_cycle", 32'(w_tx_err), 32'd0);

        result = 8'h66; w_rx_empty = 1'b0;
        tick(1);
        check("wd_new_rd", 32'(w_rd), 32'd1);
        check("wd_new_d_in", 32'(w_d_in), 32'h66);
        w_rx_empty = 1'b1;
        tick(1);
        check("wd_new_start", 32'(w_tx_start), 32'd1);
        tick(3);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("wd_new_done", 32'({w_busy, w_tx_err}), 32'd0);

        // done tick coinciding with the last watchdog cycle
        result = 8'h99; w_rx_empty = 1'b0;
        tick(1);
        w_rx_empty = 1'b1;
        tick(1);
        check("wd_coinc_start", 32'(w_tx_start), 32'd1);
        tick(15);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        check("wd_coinc_state", 32'({w_busy, w_tx_err}), 32'd0);
        tick(1);
        check("wd_coinc_no_err", 32'(w_tx_err), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("main_idle_final", 32'({tx_start, rd, busy, tx_err}), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
